pipeline_ctrl: RTL

//  Sequencing controller for the 3-stage (IF/ID/EX) open_risc_v core.

---
 rtl/pipeline_ctrl_pkg.sv | 33 +++
 rtl/pipeline_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state
// encoding, NOP encoding, default reset vector and the per-stage control bundle.
package pipeline_ctrl_pkg;

    localparam logic [1:0] ST_BOOT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_WAIT_MC = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    // addi x0,x0,0 -- what a flushed pipe register holds
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;

    typedef struct packed {
        logic hold_pc;
        logic hold_ifid;
        logic hold_idex;
        logic flush_ifid;
        logic flush_idex;
        logic rd_we_gate;
    } stage_ctrl_t;

    // Everything frozen and flushed, no writeback
    localparam stage_ctrl_t CTRL_BOOT  = '{hold_pc: 1'b1, hold_ifid: 1'b1, hold_idex: 1'b1,
                                          flush_ifid: 1'b1, flush_idex: 1'b1, rd_we_gate: 1'b0};
    // Free-running pipe with writeback
    localparam stage_ctrl_t CTRL_RUN   = '{hold_pc: 1'b0, hold_ifid: 1'b0, hold_idex: 1'b0,
                                          flush_ifid: 1'b0, flush_idex: 1'b0, rd_we_gate: 1'b1};
    // Pipe frozen in place, no writeback
    localparam stage_ctrl_t CTRL_STALL = '{hold_pc: 1'b1, hold_ifid: 1'b1, hold_idex: 1'b1,
                                          flush_ifid: 1'b0, flush_idex: 1'b0, rd_we_gate: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    // Clear wins over increment; increment stops at the top value
    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + WIDTH'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 3-stage IF/ID/EX core: redirect/flush on
// taken jumps, stall around multi-cycle EX ops with timeout, debug halt/resume.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR),
    parameter int              MC_TIMEOUT = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              mc_start_i,
    input  logic              mc_done_i,
    input  logic              halt_req_i,
    input  logic              resume_i,
    output logic              pc_load_o,
    output logic [ADDR_W-1:0] pc_load_addr_o,
    output logic              hold_pc_o,
    output logic              hold_ifid_o,
    output logic              hold_idex_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              rd_we_gate_o,
    output logic              halted_o,
    output logic              mc_abort_o,
    output logic              mc_err_o,
    output logic [31:0]       stall_cnt_o
);

    localparam int              TO_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

    logic [1:0]      state, nxt_state;
    logic [TO_W-1:0] to_cnt;
    logic            halt_blk;   // set by resume while halt_req_i still high
    stage_ctrl_t     ctrl;

    // Per-stage controls and next state from current state and EX events
    always_comb begin
        ctrl           = CTRL_RUN;
        nxt_state      = state;
        pc_load_o      = 1'b0;
        pc_load_addr_o = '0;
        halted_o       = 1'b0;
        mc_abort_o     = 1'b0;
        if (!sys_rst_n) begin
            ctrl      = CTRL_BOOT;
            nxt_state = ST_BOOT;
        end else begin
            case (state)
                ST_BOOT: begin
                    ctrl           = CTRL_BOOT;
                    pc_load_o      = 1'b1;
                    pc_load_addr_o = RESET_ADDR;
                    nxt_state      = ST_RUN;
                end
                ST_RUN: begin
                    // jump > mc_start > halt; a jump alongside mc_start drops the mc op
                    if (jump_en_i) begin
                        pc_load_o       = 1'b1;
                        pc_load_addr_o  = jump_addr_i;
                        ctrl.flush_ifid = 1'b1;
                        ctrl.flush_idex = 1'b1;
                    end else if (mc_start_i) begin
                        nxt_state = ST_WAIT_MC;
                    end else if (halt_req_i && !halt_blk) begin
                        nxt_state = ST_HALT;
                    end
                end
                ST_WAIT_MC: begin
                    ctrl = CTRL_STALL;
                    if (mc_done_i) begin
                        ctrl.rd_we_gate = 1'b1;
                        nxt_state       = ST_RUN;
                    end else if (to_cnt == TO_LAST) begin
                        mc_abort_o      = 1'b1;
                        ctrl.flush_idex = 1'b1;
                        nxt_state       = ST_RUN;
                    end
                end
                default: begin
                    ctrl     = CTRL_STALL;
                    halted_o = 1'b1;
                    if (resume_i)
                        nxt_state = ST_RUN;
                end
            endcase
        end
    end

    assign hold_pc_o    = ctrl.hold_pc;
    assign hold_ifid_o  = ctrl.hold_ifid;
    assign hold_idex_o  = ctrl.hold_idex;
    assign flush_ifid_o = ctrl.flush_ifid;
    assign flush_idex_o = ctrl.flush_idex;
    assign rd_we_gate_o = ctrl.rd_we_gate;

    // State, WAIT_MC cycle counter, sticky timeout flag and halt re-arm flop
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state    <= ST_BOOT;
            to_cnt   <= '0;
            mc_err_o <= 1'b0;
            halt_blk <= 1'b0;
        end else begin
            state  <= nxt_state;
            // counter sits at zero outside WAIT_MC so each op starts fresh
            to_cnt <= (state == ST_WAIT_MC) ? to_cnt + TO_W'(1) : '0;
            if (mc_abort_o)
                mc_err_o <= 1'b1;
            if (!halt_req_i)
                halt_blk <= 1'b0;
            else if ((state == ST_HALT) && resume_i)
                halt_blk <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk (sys_clk),
        .clr (!sys_rst_n),
        .inc (hold_pc_o && (state != ST_BOOT)),
        .cnt (stall_cnt_o)
    );

endmodule
